drum_column_pipe: RTL and testbench
===================================

# drum_column_pipe

Parametrised, pipelined successor of the drum-node column processor. It holds one column of a 2-D finite-difference drum mesh (current and previous displacement in two simple dual-port RAMs) and advances the whole column by one time step per `start`, at one row per clock once the pipeline is full. Columns placed side by side run in lockstep: each column's `u_now` feeds its neighbours' `u_left`/`u_right`. The top-level mesh instantiates NCOL copies.

## Interface
- `DW`, 18: data width, signed two's complement.
- `FRAC`, 17: fractional bits (`DW=18`, `FRAC=17` gives 1.17 format).
- `MAX_ROWS`, 512: RAM depth.
- `AW`, `$clog2(MAX_ROWS)`: row address width.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `column_size` in AW+1: rows N. Latched at start; legal range 2..MAX_ROWS.
- `column_num` in AW: column index, used for pyramid init.
- `pyramid_step` in 5: init shift.
- `rho` in DW: wave coefficient.
- `eta_term` in 5: damping shift.
- `start` in 1: single-cycle request.
- `u_left`, `u_right` in DW: neighbour old-step values, same row, compute stage.
- `init_done` out 1
- `busy` out 1
- `done` out 1: one-cycle pulse.
- `size_err` out 1: sticky.
- `u_now` out DW: old-step value of the current compute row.
- `u_out` out DW: new-step value of the current compute row.
- `u_out_valid` out 1
- `u_out_row` out AW
- `u_center` out DW: new value of row N>>1, held.
- `cycles_per_update` out 32

## Operation
- FSM states: INIT, IDLE, PRIME, RUN, FLUSH. `reset` forces INIT from any state, including mid-RUN.
- **Reset values.** Every output is 0. INIT then sweeps rows 0..N-1, one row per cycle, using the live `column_size`.
  - Both RAMs get `(min(fold(row), fold(column_num)) + 1) << pyramid_step`, where `fold(x) = x >= N/2 ? N-1-x : x`.
  - A shift of DW or more writes 0.
  - After the sweep `init_done` rises and the FSM moves to IDLE.
- **Start acceptance.** `start` is accepted only in IDLE with `init_done`=1. It is ignored otherwise and carries no queueing.
  - If `column_size` is outside 2..MAX_ROWS, `size_err` is set and the FSM stays in IDLE.
  - `size_err` clears only on reset.
- **Sliding window.** The u-RAM is read at rows 0,1,..,N-1. Registers `down`, `center` and `up` hold u(r-1), u(r) and u(r+1).
  - Out-of-range rows read as 0 (fixed boundary): `down`=0 at row 0, `up`=0 at row N-1.
  - The prev-RAM is read at row r, aligned with the same compute stage.
- **Compute.** Intermediates are DW+4 bits signed; each is saturated to DW only at the end.
  - `lap = up + down + u_left + u_right - 4*center`.
  - `t1 = (rho*lap) >>> FRAC`.
  - `d(x) = x - (x >>> eta)`, with `eta=0` meaning no damping (`d(x) = x`).
  - `u_next = sat(d(2*center + t1 - d(prev)))`.
- **Write-back at compute of row r.**
  - u-RAM[r] takes `u_next`.
  - prev-RAM[r] takes `center`, the old u(r).
  - The read of row r+1 was issued earlier, so there is no read/write collision.
- **Outputs at compute of row r.** `u_now` = center, `u_out` = u_next, `u_out_row` = r, `u_out_valid` = 1.
  - If r == N>>1, `u_center` takes u_next.

## Timing
- Cycle 0: start accepted.
- Cycle r+1: read address r is registered.
- Cycle r+2: RAM data for row r arrives.
- Cycle r+3: compute stage for row r; `u_now`/`u_out` are valid in the same cycle.
- Row N-1 computes at cycle N+2. FLUSH is cycle N+3, when `done` pulses.
- `busy` is high for cycles 1..N+3. The next start can be accepted at cycle N+4.
- `u_left`/`u_right` are consumed combinationally in the compute cycle. Lockstep columns therefore have no skew.
- `cycles_per_update` is loaded at `done` with start-to-done cycles (N+3).

## Structure
- **Shared package `drum_pkg`:**
  - state enum
  - `sat_dw` function
  - `fold` function
  - `d()` damping function
  - default DW/FRAC constants
- **Sub-module `drum_node_alu`:** combinational compute, saturating; reused by other mesh blocks.
- **RAMs:** two instances of the existing simple dual-port M10K wrapper, parametrised to `DW` × `MAX_ROWS`.

## Test plan
- Reset, N=8, `column_num`=2, `pyramid_step`=4 -> after 8 INIT cycles, `init_done`=1 and RAM rows read 16,32,48,48,48,48,32,16.
- Init as above, `rho`=0, `eta`=0, `u_left`/`u_right`=0, start -> `u_out` rows equal the init values, `done` at cycle 11, `cycles_per_update`=11.
- `pyramid_step`=31 (zero column), `rho`=0x10000, `eta`=0, `u_left`=`u_right`=0x1FFFF -> every `u_out`=0x1FFFF (saturated), never wraps negative.
- `eta`=1, zero column, `rho`=0x10000, `u_left`=0x08000, `u_right`=0 -> each row's `u_out`=0x02000; `u_center` (row 4)=0x02000.
- Start during RUN, and start with `column_size`=1 -> the RUN start is ignored with no timing change; the size-1 start sets `size_err`=1 and leaves `busy`=0.
- Assert `reset` at cycle 5 of RUN -> all outputs are 0 asynchronously and INIT re-runs; the next update matches a fresh-reset run.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared definitions for the drum mesh blocks: FSM state type, default
// fixed-point format and the saturate / fold / damping helpers.
package drum_pkg;

    localparam int DW_DEF   = 18;
    localparam int FRAC_DEF = 17;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

    // Clamp a sign-extended value into the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            sat_dw = hi;
        end else if (x < lo) begin
            sat_dw = lo;
        end else begin
            sat_dw = x;
        end
    endfunction

    // Mirror an index about the middle of an n-long column.
    function automatic int fold(input int x, input int n);
        if (x >= n / 2) begin
            fold = n - 1 - x;
        end else begin
            fold = x;
        end
    endfunction

    // Damping d(x) = x - (x >>> eta); eta of zero disables damping.
    function automatic logic signed [63:0] damp(input logic signed [63:0] x, input logic [4:0] eta);
        if (eta == 5'd0) begin
            damp = x;
        end else begin
            damp = x - (x >>> eta);
        end
    endfunction

endpackage

// File: rtl/drum_node_alu.sv
// Combinational finite-difference node update with damping. Intermediates
// carry four guard bits; only the final result is saturated to DW.
module drum_node_alu
    import drum_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [DW-1:0] up_i,
    input  logic signed [DW-1:0] down_i,
    input  logic signed [DW-1:0] center_i,
    input  logic signed [DW-1:0] left_i,
    input  logic signed [DW-1:0] right_i,
    input  logic signed [DW-1:0] prev_i,
    input  logic signed [DW-1:0] rho_i,
    input  logic [4:0]           eta_i,
    output logic signed [DW-1:0] u_next_o
);

    localparam int IW = DW + 4;
    localparam int PW = DW + IW;

    logic signed [IW-1:0] lap_s;
    logic signed [PW-1:0] prod_s;
    logic signed [IW-1:0] t1_s;
    logic signed [IW-1:0] dprev_s;
    logic signed [IW-1:0] sum_s;
    logic signed [IW-1:0] dsum_s;

    // Laplacian, scaled wave term, damped leapfrog update, final saturation.
    always_comb begin
        lap_s    = IW'(up_i) + IW'(down_i) + IW'(left_i) + IW'(right_i) - (IW'(center_i) <<< 2);
        prod_s   = PW'(rho_i) * PW'(lap_s);
        t1_s     = IW'(prod_s >>> FRAC);
        dprev_s  = IW'(damp(64'(prev_i), eta_i));
        sum_s    = (IW'(center_i) <<< 1) + t1_s - dprev_s;
        dsum_s   = IW'(damp(64'(sum_s), eta_i));
        u_next_o = DW'(sat_dw(64'(dsum_s), DW));
    end

endmodule

// File: rtl/drum_sdp_ram.sv
// Simple dual-port RAM (one write port, one registered read port) in the
// shape a block RAM primitive expects; no reset on the storage.
module drum_sdp_ram #(
    parameter int DW    = 18,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Synchronous write and registered read; a same-address read returns old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/drum_column_pipe.sv
// One column of the drum mesh: pyramid init, then one row per clock through
// read -> data -> compute stages, writing the new and old steps back.
module drum_column_pipe
    import drum_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int MAX_ROWS = 512,
    parameter int AW       = $clog2(MAX_ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW:0]          column_size,
    input  logic [AW-1:0]        column_num,
    input  logic [4:0]           pyramid_step,
    input  logic signed [DW-1:0] rho,
    input  logic [4:0]           eta_term,
    input  logic                 start,
    input  logic signed [DW-1:0] u_left,
    input  logic signed [DW-1:0] u_right,
    output logic                 init_done,
    output logic                 busy,
    output logic                 done,
    output logic                 size_err,
    output logic signed [DW-1:0] u_now,
    output logic signed [DW-1:0] u_out,
    output logic                 u_out_valid,
    output logic [AW-1:0]        u_out_row,
    output logic signed [DW-1:0] u_center,
    output logic [31:0]          cycles_per_update
);

    localparam logic [AW:0] MAX_N = (AW+1)'(MAX_ROWS);

    state_e               state_q, state_d;
    logic [AW:0]          n_q, n_m1_s, half_s, size_m1_s;
    logic [AW-1:0]        init_row_q, init_last_s;
    logic                 init_done_q, size_ok_s, start_ok_s, go_s;
    logic [AW-1:0]        rd_cnt_q, dat_row_q, cmp_row_q;
    logic                 rd_vld_q, dat_vld_q, cmp_vld_q, cmp_last_s, done_d_s;
    logic signed [DW-1:0] down_q, center_q, prev_q, up_s, u_rdata_s, p_rdata_s;
    logic signed [DW-1:0] u_next_s, init_val_s, wu_s, wp_s;
    logic                 we_s;
    logic [AW-1:0]        waddr_s;
    logic                 done_q, busy_q, size_err_q;
    logic signed [DW-1:0] u_center_q;
    logic [31:0]          cyc_q, cpu_q;
    int                   fold_row_s, fold_col_s, pyr_s;

    // Start qualification, init sweep bound and pipeline row decodes.
    always_comb begin
        size_m1_s  = column_size - (AW+1)'(1);
        n_m1_s     = n_q - (AW+1)'(1);
        half_s     = n_q >> 1;
        size_ok_s  = (column_size >= (AW+1)'(2)) && (column_size <= MAX_N);
        start_ok_s = start && (state_q == ST_IDLE) && init_done_q;
        go_s       = start_ok_s && size_ok_s;
        cmp_last_s = (cmp_row_q == n_m1_s[AW-1:0]);
        done_d_s   = (state_q == ST_RUN) && cmp_vld_q && cmp_last_s;
        if (column_size == '0) begin
            init_last_s = '0;
        end else if (column_size > MAX_N) begin
            init_last_s = AW'(MAX_ROWS - 1);
        end else begin
            init_last_s = size_m1_s[AW-1:0];
        end
    end

    // Pyramid initial value for the row being swept, using the live size.
    always_comb begin
        fold_row_s = fold(int'(init_row_q), int'(column_size));
        fold_col_s = fold(int'(column_num), int'(column_size));
        pyr_s      = ((fold_row_s < fold_col_s) ? fold_row_s : fold_col_s) + 1;
        if (int'(pyramid_step) >= DW) begin
            init_val_s = '0;
        end else begin
            init_val_s = DW'(pyr_s << pyramid_step);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_row_q == init_last_s) state_d = ST_IDLE; else state_d = ST_INIT;
            ST_IDLE:  if (go_s) state_d = ST_PRIME; else state_d = ST_IDLE;
            ST_PRIME: state_d = ST_RUN;
            ST_RUN:   if (done_d_s) state_d = ST_FLUSH; else state_d = ST_RUN;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // Write port: init sweep fills both RAMs, compute stage writes new/old step.
    always_comb begin
        if (state_q == ST_INIT) begin
            we_s = 1'b1; waddr_s = init_row_q; wu_s = init_val_s; wp_s = init_val_s;
        end else if (cmp_vld_q) begin
            we_s = 1'b1; waddr_s = cmp_row_q;  wu_s = u_next_s;   wp_s = center_q;
        end else begin
            we_s = 1'b0; waddr_s = cmp_row_q;  wu_s = '0;         wp_s = '0;
        end
    end

    drum_sdp_ram #(.DW(DW), .DEPTH(MAX_ROWS), .AW(AW)) u_ram (
        .clk(clk), .we_i(we_s), .waddr_i(waddr_s), .wdata_i(wu_s),
        .raddr_i(rd_cnt_q), .rdata_o(u_rdata_s)
    );

    drum_sdp_ram #(.DW(DW), .DEPTH(MAX_ROWS), .AW(AW)) p_ram (
        .clk(clk), .we_i(we_s), .waddr_i(waddr_s), .wdata_i(wp_s),
        .raddr_i(rd_cnt_q), .rdata_o(p_rdata_s)
    );

    // The freshest RAM word is u(r+1); the last row sees the fixed boundary.
    assign up_s = cmp_last_s ? '0 : u_rdata_s;

    drum_node_alu #(.DW(DW), .FRAC(FRAC)) u_alu (
        .up_i(up_s), .down_i(down_q), .center_i(center_q), .left_i(u_left),
        .right_i(u_right), .prev_i(prev_q), .rho_i(rho), .eta_i(eta_term),
        .u_next_o(u_next_s)
    );

    // Read counter, stage valids and the u(r-1)/u(r)/prev(r) window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0; rd_vld_q <= 1'b0; dat_row_q <= '0; dat_vld_q <= 1'b0;
            cmp_row_q <= '0; cmp_vld_q <= 1'b0;
            down_q <= '0; center_q <= '0; prev_q <= '0;
        end else begin
            dat_vld_q <= rd_vld_q;
            dat_row_q <= rd_cnt_q;
            cmp_vld_q <= dat_vld_q;
            cmp_row_q <= dat_row_q;
            if (state_q == ST_PRIME) begin
                rd_cnt_q <= '0;
                rd_vld_q <= 1'b1;
            end else if (rd_vld_q) begin
                if (rd_cnt_q == n_m1_s[AW-1:0]) rd_vld_q <= 1'b0;
                else                            rd_cnt_q <= rd_cnt_q + AW'(1);
            end
            if (go_s) begin
                down_q   <= '0;
                center_q <= '0;
            end else if (dat_vld_q) begin
                down_q   <= center_q;
                center_q <= u_rdata_s;
                prev_q   <= p_rdata_s;
            end
        end
    end

    // Init sweep, size latch, status flags, held centre value and cycle count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_row_q <= '0; init_done_q <= 1'b0; n_q <= '0;
            done_q <= 1'b0; busy_q <= 1'b0; size_err_q <= 1'b0;
            u_center_q <= '0; cyc_q <= '0; cpu_q <= '0;
        end else begin
            if (state_q == ST_INIT) begin
                if (init_row_q == init_last_s) init_done_q <= 1'b1;
                else                           init_row_q  <= init_row_q + AW'(1);
            end
            if (go_s) n_q <= column_size;
            if (start_ok_s && !size_ok_s) size_err_q <= 1'b1;
            done_q <= done_d_s;
            busy_q <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
            if (cmp_vld_q && (cmp_row_q == half_s[AW-1:0])) u_center_q <= u_next_s;
            if (go_s) cyc_q <= '0;
            else if ((state_q == ST_PRIME) || (state_q == ST_RUN)) cyc_q <= cyc_q + 32'd1;
            if (done_d_s) cpu_q <= cyc_q + 32'd1;
        end
    end

    assign init_done         = init_done_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign size_err          = size_err_q;
    assign u_now             = cmp_vld_q ? center_q : '0;
    assign u_out             = cmp_vld_q ? u_next_s : '0;
    assign u_out_valid       = cmp_vld_q;
    assign u_out_row         = cmp_row_q;
    assign u_center          = u_center_q;
    assign cycles_per_update = cpu_q;

endmodule

// File: tb/tb_drum_column_pipe.sv
// Directed bench for drum_column_pipe (N=8): stimulus pushes expected rows
// into a queue, a negedge monitor pops and compares every valid output row.
module tb_drum_column_pipe;

    localparam int DW = 18;
    localparam int AW = 9;
    localparam int N  = 8;

    logic          clk, reset, start;
    logic [AW:0]   column_size;
    logic [AW-1:0] column_num;
    logic [4:0]    pyramid_step, eta_term;
    logic [DW-1:0] rho, u_left, u_right;
    logic          init_done, busy, done, size_err, u_out_valid;
    logic [DW-1:0] u_now, u_out, u_center;
    logic [AW-1:0] u_out_row;
    logic [31:0]   cycles_per_update;

    typedef struct {
        int            row;
        logic [DW-1:0] now;
        logic [DW-1:0] out;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] pyr [N];

    drum_column_pipe dut (
        .clk(clk), .reset(reset), .column_size(column_size), .column_num(column_num),
        .pyramid_step(pyramid_step), .rho(rho), .eta_term(eta_term), .start(start),
        .u_left(u_left), .u_right(u_right), .init_done(init_done), .busy(busy),
        .done(done), .size_err(size_err), .u_now(u_now), .u_out(u_out),
        .u_out_valid(u_out_valid), .u_out_row(u_out_row), .u_center(u_center),
        .cycles_per_update(cycles_per_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int r, input logic [DW-1:0] now_v, input logic [DW-1:0] out_v);
        exp_t e;
        e.row = r; e.now = now_v; e.out = out_v;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid output row must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && u_out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_row: got row %0d u_out 0x%0h, expected no output", u_out_row, u_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("u_out_row", 32'(u_out_row), 32'(mon_e.row));
                check("u_now", 32'(u_now), 32'(mon_e.now));
                check("u_out", 32'(u_out), 32'(mon_e.out));
            end
        end
    end

    task automatic all_zero(input string tag);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_size_err"}, 32'(size_err), 32'd0);
        check({tag, "_u_now"}, 32'(u_now), 32'd0);
        check({tag, "_u_out"}, 32'(u_out), 32'd0);
        check({tag, "_valid"}, 32'(u_out_valid), 32'd0);
        check({tag, "_row"}, 32'(u_out_row), 32'd0);
        check({tag, "_u_center"}, 32'(u_center), 32'd0);
        check({tag, "_cycles"}, cycles_per_update, 32'd0);
    endtask

    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_init_cycles"}, 32'(cnt), 32'(N));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        all_zero(tag);
        @(negedge clk);
        reset = 1'b0;
        wait_init(tag);
    endtask

    // One update; inj>0 raises start again during cycle inj of the run.
    task automatic run_update(input string tag, input logic [DW-1:0] ctr, input int inj);
        int cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            start = (cnt == inj);
            if (cnt == 1) check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 32'(cnt), 32'(N + 3));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        check({tag, "_cycles_per_update"}, cycles_per_update, 32'(N + 3));
        check({tag, "_u_center"}, 32'(u_center), 32'(ctr));
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_rows_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        pyr = '{18'd16, 18'd32, 18'd48, 18'd48, 18'd48, 18'd48, 18'd32, 18'd16};
        reset = 1'b1; start = 1'b0; column_size = 10'd8; column_num = 9'd2;
        pyramid_step = 5'd4; rho = '0; eta_term = 5'd0; u_left = '0; u_right = '0;

        // Pyramid init, identity update (rho=0, no damping).
        do_reset("rst1");
        for (int r = 0; r < N; r++) push_exp(r, pyr[r], pyr[r]);
        run_update("pyr", 18'd48, 0);

        // Same again with a stray start mid-run: no timing change.
        for (int r = 0; r < N; r++) push_exp(r, pyr[r], pyr[r]);
        run_update("pyr_midstart", 18'd48, 4);

        // Illegal size start: sticky error, no run.
        column_size = 10'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("size_err_set", 32'(size_err), 32'd1);
        check("size_err_busy", 32'(busy), 32'd0);
        column_size = 10'd8;

        // Zero column, strong neighbour drive, then true saturation.
        pyramid_step = 5'd31;
        do_reset("rst_zero");
        rho = 18'h10000; u_left = 18'h1FFFF; u_right = 18'h1FFFF;
        for (int r = 0; r < N; r++) push_exp(r, 18'h0, 18'h1FFFF);
        run_update("sat1", 18'h1FFFF, 0);
        for (int r = 0; r < N; r++) push_exp(r, 18'h1FFFF, 18'h1FFFF);
        run_update("sat2", 18'h1FFFF, 0);

        // Damping eta=1 from a zero column, then a second step with boundaries.
        do_reset("rst_eta");
        u_left = 18'h08000; u_right = 18'h0; eta_term = 5'd1;
        for (int r = 0; r < N; r++) push_exp(r, 18'h0, 18'h02000);
        run_update("eta1", 18'h02000, 0);
        for (int r = 0; r < N; r++)
            push_exp(r, 18'h02000, (r == 0 || r == N - 1) ? 18'h02800 : 18'h03000);
        run_update("eta2", 18'h03000, 0);

        // Reset in the middle of a run, then a fresh update.
        pyramid_step = 5'd4; rho = '0; eta_term = 5'd0; u_left = '0; u_right = '0;
        do_reset("rst_pre");
        for (int r = 0; r < N; r++) push_exp(r, pyr[r], pyr[r]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        all_zero("async_rst");
        check("midrun_rows_left", 32'(exp_q.size()), 32'(N - 3));
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        wait_init("rst_mid");
        for (int r = 0; r < N; r++) push_exp(r, pyr[r], pyr[r]);
        run_update("fresh", 18'd48, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
